// File: rtl/sliding_window_buffer_pkg.sv
// ---------------------------------------------------------------------------
// sliding_window_buffer_pkg
// Shared definitions for the sliding-window line buffer:
//   DEFAULT_DATA_WIDTH - default pixel width in bits
//   calc_depth()       - shift-chain length needed to cover a KxK window
//   coord_width()      - counter width for a range 0..n-1 (never below 1)
//   state_e            - window-generator FSM states
// ---------------------------------------------------------------------------
package sliding_window_buffer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // (K-1) full image rows plus K pixels of the current row span every
    // element of a KxK window whose bottom-right corner is the newest pixel.
    function automatic int calc_depth(input int kernel_size, input int ifm_size);
        return (kernel_size - 1) * ifm_size + kernel_size;
    endfunction

    function automatic int coord_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        FILL   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/sliding_window_buffer_shift_chain.sv
// ---------------------------------------------------------------------------
// sliding_window_buffer_shift_chain
// Enable-gated shift register exposing every stage as a flat tap bus.
// Tap 0 (lowest WIDTH bits) always holds the most recently shifted-in word.
// Ports:
//   clk     in   clock
//   reset   in   asynchronous, active-high; zeroes all taps
//   enable  in   shift one position on this edge
//   data    in   WIDTH-bit word entering tap 0
//   taps    out  DEPTH*WIDTH flat bus, tap t at [t*WIDTH +: WIDTH]
// ---------------------------------------------------------------------------
module sliding_window_buffer_shift_chain
    import sliding_window_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       data,
    output logic [DEPTH*WIDTH-1:0] taps
);

    // NOTE: this storage is reset on purpose: the consumer relies on an
    // all-zero window straight out of reset. A pure data pipe with its own
    // valid qualifier would normally leave such storage unreset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taps <= '0;
        end else if (enable) begin
            taps <= {taps[(DEPTH-1)*WIDTH-1:0], data};
        end
    end

endmodule

// File: rtl/sliding_window_buffer.sv
// ---------------------------------------------------------------------------
// sliding_window_buffer
// Line-buffer window generator: takes a raster-order IFM_SIZE x IFM_SIZE
// pixel stream and presents the KERNEL_SIZE x KERNEL_SIZE window whose
// bottom-right corner is the newest pixel. window_valid qualifies windows
// that lie fully inside the map and fall on the STRIDE grid.
// Ports:
//   clk           in   clock
//   reset         in   asynchronous, active-high
//   clear         in   synchronous frame restart (counters/FSM/flags only)
//   in_valid      in   pixel accepted on this edge
//   in_data       in   pixel value
//   window        out  flat window, element i*K+j at [(i*K+j)*DATA_WIDTH +: DATA_WIDTH]
//   window_valid  out  window is legal and stride-aligned
//   frame_done    out  one-cycle pulse alongside the final window of a frame
//   out_row       out  top-left row of the current window
//   out_col       out  top-left column of the current window
// ---------------------------------------------------------------------------
module sliding_window_buffer
    import sliding_window_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int IFM_SIZE    = 32,
    parameter int KERNEL_SIZE = 5,
    parameter int STRIDE      = 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        clear,
    input  logic                                        in_valid,
    input  logic [DATA_WIDTH-1:0]                       in_data,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window,
    output logic                                        window_valid,
    output logic                                        frame_done,
    output logic [coord_width(IFM_SIZE)-1:0]            out_row,
    output logic [coord_width(IFM_SIZE)-1:0]            out_col
);

    localparam int DEPTH = calc_depth(KERNEL_SIZE, IFM_SIZE);
    localparam int CW    = coord_width(IFM_SIZE);
    localparam int PW    = coord_width(STRIDE);

    localparam logic [CW-1:0] K_LAST = CW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] N_LAST = CW'(IFM_SIZE - 1);
    localparam logic [PW-1:0] P_LAST = PW'(STRIDE - 1);

    logic [DEPTH*DATA_WIDTH-1:0] taps;
    logic [CW-1:0]               col, row;
    logic [CW-1:0]               col_inc, row_inc;
    logic [PW-1:0]               cphase, rphase;
    logic                        accept;
    logic                        frame_last;
    logic                        window_hit;
    state_e                      state, state_next;

    assign accept     = in_valid && !clear;
    assign col_inc    = col + CW'(1);
    assign row_inc    = row + CW'(1);
    assign frame_last = (col == N_LAST) && (row == N_LAST);

    // ------------------------------------------------------------------
    // Pixel storage
    // ------------------------------------------------------------------
    sliding_window_buffer_shift_chain #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_chain (
        .clk    (clk),
        .reset  (reset),
        .enable (accept),
        .data   (in_data),
        .taps   (taps)
    );

    // Element (i,j) from the top-left sits (K-1-i) rows and (K-1-j)
    // columns behind the newest pixel in raster order.
    for (genvar i = 0; i < KERNEL_SIZE; i++) begin : g_win_row
        for (genvar j = 0; j < KERNEL_SIZE; j++) begin : g_win_col
            localparam int TAP = (KERNEL_SIZE - 1 - i) * IFM_SIZE + (KERNEL_SIZE - 1 - j);
            assign window[(i*KERNEL_SIZE + j)*DATA_WIDTH +: DATA_WIDTH] =
                taps[TAP*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Taps between window rows are only line storage and never reach a port.
    logic unused_taps;
    assign unused_taps = ^taps;

    // ------------------------------------------------------------------
    // FSM: FILL until the first pixel of row K-1, ACTIVE through the end
    // of the frame. window_hit reports whether the pixel being accepted
    // completes a legal, stride-aligned window.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILL;
        end else if (clear) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves it unassigned, which would otherwise infer a latch.
        state_next = state;
        window_hit = 1'b0;
        case (state)
            FILL: begin
                if (accept && row == K_LAST && col == '0) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                window_hit = (col >= K_LAST) && (rphase == '0) && (cphase == '0);
                if (accept && frame_last) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // Coordinate / phase counters and registered window qualifiers.
    // Phases restart at coordinate K-1 so the first legal window is always
    // on the stride grid; counting avoids any division or modulo.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // here samples the pre-edge values of the others, independent of order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col          <= '0;
            row          <= '0;
            cphase       <= '0;
            rphase       <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            out_row      <= '0;
            out_col      <= '0;
        end else if (clear) begin
            col          <= '0;
            row          <= '0;
            cphase       <= '0;
            rphase       <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (in_valid) begin
                window_valid <= window_hit;
                frame_done   <= window_hit && frame_last;
                if (window_hit) begin
                    out_row <= row - K_LAST;
                    out_col <= col - K_LAST;
                end

                if (col == N_LAST) begin
                    col    <= '0;
                    cphase <= '0;
                    if (row == N_LAST) begin
                        row    <= '0;
                        rphase <= '0;
                    end else begin
                        row    <= row_inc;
                        rphase <= (row_inc == K_LAST || rphase == P_LAST) ? '0 : rphase + PW'(1);
                    end
                end else begin
                    col    <= col_inc;
                    cphase <= (col_inc == K_LAST || cphase == P_LAST) ? '0 : cphase + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sliding_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_sliding_window_buffer
// Directed bench for sliding_window_buffer. Instances:
//   dut_a : K=3, IFM=5, S=1
//   dut_b : K=3, IFM=5, S=2   (shares stimulus with dut_a)
//   dut_c : K=5, IFM=32, S=1  (defaults, own stimulus)
// Expected windows come from the ramp formula: pixel (r,c) = base + r*5 + c.
// ---------------------------------------------------------------------------
module tb_sliding_window_buffer;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clear, in_valid, in_valid_c;
    logic [31:0] in_data, in_data_c;

    logic [9*DW-1:0]  win_a, win_b;
    logic [25*DW-1:0] win_c;
    logic             wv_a, wv_b, wv_c, fd_a, fd_b, fd_c;
    logic [2:0]       or_a, oc_a, or_b, oc_b;
    logic [4:0]       or_c, oc_c;

    sliding_window_buffer #(.DATA_WIDTH(DW), .IFM_SIZE(5), .KERNEL_SIZE(3), .STRIDE(1)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .window(win_a), .window_valid(wv_a), .frame_done(fd_a), .out_row(or_a), .out_col(oc_a)
    );

    sliding_window_buffer #(.DATA_WIDTH(DW), .IFM_SIZE(5), .KERNEL_SIZE(3), .STRIDE(2)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .window(win_b), .window_valid(wv_b), .frame_done(fd_b), .out_row(or_b), .out_col(oc_b)
    );

    sliding_window_buffer dut_c (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid_c), .in_data(in_data_c),
        .window(win_c), .window_valid(wv_c), .frame_done(fd_c), .out_row(or_c), .out_col(oc_c)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [299:0] actual, input logic [299:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [9*DW-1:0] exp_win(input int base, input int r, input int c);
        logic [9*DW-1:0] w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(i*3 + j)*DW +: DW] = 32'(base + (r + i)*5 + (c + j));
        return w;
    endfunction

    function automatic logic exp_valid(input int r, input int c, input int s);
        return (r >= 2) && (c >= 2) && ((r - 2) % s == 0) && ((c - 2) % s == 0);
    endfunction

    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Compare both 5x5 instances against the state expected after pixel (r,c).
    task automatic check_pixel(input int base, input int r, input int c, input logic last);
        logic va, vb;
        va = exp_valid(r, c, 1);
        vb = exp_valid(r, c, 2);
        check("valid_a", wv_a, va);
        check("valid_b", wv_b, vb);
        check("done_a", fd_a, va && last);
        check("done_b", fd_b, vb && last);
        if (va) begin
            check("win_a", win_a, exp_win(base, r - 2, c - 2));
            check("row_a", or_a, r - 2);
            check("col_a", oc_a, c - 2);
        end
        if (vb) begin
            check("win_b", win_b, exp_win(base, r - 2, c - 2));
            check("row_b", or_b, r - 2);
            check("col_b", oc_b, c - 2);
        end
    endtask

    // One full 5x5 frame of ramp base..base+24, optionally with idle gaps
    // during which outputs must hold (frame_done must already have dropped).
    task automatic run_frame(input int base, input logic gaps);
        int na = 0;
        int nb = 0;
        for (int p = 0; p < 25; p++) begin
            push(32'(base + p));
            check_pixel(base, p / 5, p % 5, p == 24);
            if (wv_a) na++;
            if (wv_b) nb++;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                    check_pixel(base, p / 5, p % 5, 1'b0);
                end
            end
        end
        check("count_a", na, 9);
        check("count_b", nb, 4);
    endtask

    initial begin
        int cnt_c, first_c;

        reset      = 1'b1;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_valid_c = 1'b0;
        in_data_c  = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_win_a", win_a, '0);
        check("rst_valid_a", wv_a, 1'b0);
        check("rst_done_a", fd_a, 1'b0);
        check("rst_row_a", or_a, 0);
        check("rst_col_a", oc_a, 0);
        check("rst_valid_c", wv_c, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Continuous frame, then a back-to-back frame with random gaps
        run_frame(0, 1'b0);
        run_frame(0, 1'b1);

        // clear after pixel 17; the pixel presented with clear is dropped
        for (int p = 0; p < 18; p++) push(32'(p));
        check("pre_clear_valid_a", wv_a, 1'b1);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd999;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_valid_a", wv_a, 1'b0);
        check("clear_valid_b", wv_b, 1'b0);
        check("clear_done_a", fd_a, 1'b0);
        run_frame(100, 1'b0);

        // Asynchronous reset mid-frame, between clock edges
        for (int p = 0; p < 14; p++) push(32'(p));
        check("pre_reset_valid_a", wv_a, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_win_a", win_a, '0);
        check("async_valid_a", wv_a, 1'b0);
        check("async_row_a", or_a, 0);
        check("async_col_a", oc_a, 0);
        check("async_win_b", win_b, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_frame(0, 1'b0);

        // Default geometry: 32x32 map, 5x5 kernel, stride 1
        cnt_c   = 0;
        first_c = 0;
        for (int p = 0; p < 1024; p++) begin
            in_valid_c = 1'b1;
            in_data_c  = 32'(p);
            @(posedge clk);
            #1;
            in_valid_c = 1'b0;
            if (wv_c) begin
                cnt_c++;
                if (cnt_c == 1) begin
                    first_c = p + 1;
                    check("c_first_e0", win_c[0*DW +: DW], 32'd0);
                    check("c_first_e1", win_c[1*DW +: DW], 32'd1);
                    check("c_first_e5", win_c[5*DW +: DW], 32'd32);
                    check("c_first_e24", win_c[24*DW +: DW], 32'd132);
                end
            end
        end
        check("c_count", cnt_c, 784);
        check("c_first_accept", first_c, 133);
        check("c_done", fd_c, 1'b1);
        check("c_last_row", or_c, 27);
        check("c_last_col", oc_c, 27);
        @(posedge clk);
        #1;
        check("c_done_drop", fd_c, 1'b0);
        check("c_valid_hold", wv_c, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
